// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Shares one unified memory port between fetch and data requesters, one transaction at a time.
// Latency: req seen in IDLE -> m_req next cycle; gnt and read data forwarded combinationally.
// Backpressure: m_gnt/m_rvalid stalls hold REQ/WAIT; requesters hold req and fields until gnt.
module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_kill,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic        m_gnt,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam int SW = $clog2(MAX_D_STREAK + 1);

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } cmd_t;

    logic [1:0]    state;
    logic          owner_d;
    logic          drop;
    logic          m_req_q;
    logic [SW-1:0] streak;
    logic [SW-1:0] streak_nxt;
    cmd_t          cmd_q;
    cmd_t          cmd_nxt;
    logic          i_ok;
    logic          d_win;
    logic          i_win;

    // Data wins by default; once the contended streak hits the limit, fetch takes one turn.
    always_comb begin
        i_ok       = i_req & ~i_kill;
        d_win      = d_req & ~(i_ok & (streak == SW'(MAX_D_STREAK)));
        i_win      = i_ok & ~d_win;
        streak_nxt = (d_win & i_ok) ? streak + SW'(1) : '0;
        if (d_win) begin
            cmd_nxt = cmd_t'{we: d_we, addr: d_addr, wdata: d_wdata, be: d_be};
        end else begin
            cmd_nxt = cmd_t'{we: 1'b0, addr: i_addr, wdata: 32'h0, be: 4'hF};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            owner_d <= 1'b0;
            drop    <= 1'b0;
            m_req_q <= 1'b0;
            streak  <= '0;
            cmd_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (d_win || i_win) begin
                        state   <= ST_REQ;
                        owner_d <= d_win;
                        drop    <= 1'b0;
                        m_req_q <= 1'b1;
                        streak  <= streak_nxt;
                        cmd_q   <= cmd_nxt;
                    end
                end
                ST_REQ: begin
                    if (i_kill && !owner_d) drop <= 1'b1;
                    if (m_gnt) begin
                        m_req_q <= 1'b0;
                        state   <= (owner_d && cmd_q.we) ? ST_IDLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A killed fetch still owns the bus until its data returns.
                    if (i_kill && !owner_d) drop <= 1'b1;
                    if (m_rvalid) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = cmd_q.we;
    assign m_addr  = cmd_q.addr;
    assign m_wdata = cmd_q.wdata;
    assign m_be    = cmd_q.be;

    assign i_gnt    = (state == ST_REQ)  & m_gnt    & ~owner_d & ~drop;
    assign d_gnt    = (state == ST_REQ)  & m_gnt    &  owner_d & ~drop;
    assign i_rvalid = (state == ST_WAIT) & m_rvalid & ~owner_d & ~drop;
    assign d_rvalid = (state == ST_WAIT) & m_rvalid &  owner_d & ~drop;
    assign i_rdata  = i_rvalid ? m_rdata : 32'h0;
    assign d_rdata  = d_rvalid ? m_rdata : 32'h0;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter sharing one unified instruction/data memory bus between the fetch stage and the memory-access stage of the RISC-V pipeline. It accepts one request at a time from either requester and presents it to the memory on a registered request/grant bus. It routes the read response back to the owning requester. Data accesses win by default; a streak limiter guarantees fetch forward progress. A kill input lets branch/jump redirects discard an in-flight fetch.

## Interface
- MAX_D_STREAK, 4, consecutive contended data grants allowed before fetch is forced to win (≥1)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held with i_addr stable until i_gnt or i_kill
- i_addr  in  32  fetch word address
- i_kill  in  1  discard current/pending fetch (pipeline redirect)
- i_gnt  out  1  fetch request accepted by memory
- i_rvalid  out  1  fetch read data valid
- i_rdata  out  32  fetch read data; 0 when i_rvalid=0
- d_req  in  1  data request; held with fields stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_be  in  4  store byte enables
- d_gnt  out  1  data request accepted
- d_rvalid  out  1  load data valid
- d_rdata  out  32  load data; 0 when d_rvalid=0
- m_req  out  1  memory request, registered
- m_we, m_addr, m_wdata, m_be  out  1/32/32/4  registered command fields
- m_gnt  in  1  memory accepts command this cycle
- m_rvalid  in  1  read data valid
- m_rdata  in  32  read data

## Operation
- State: IDLE, REQ, WAIT. Registers: owner (I/D), cmd fields, drop flag, streak counter (width $clog2(MAX_D_STREAK+1)).
- IDLE: arbitrate on sampled i_req/d_req (i_req qualified by !i_kill).
  - Only D: D wins, streak←0. Only I: I wins, streak←0.
  - Both: if streak==MAX_D_STREAK, I wins, streak←0; else D wins, streak←streak+1.
  - Winner: latch fields (fetch: m_we=0, m_be=4'hF, m_wdata=0), m_req←1, drop←0, go REQ. None: stay IDLE.
- REQ: hold m_req and fields. On m_gnt: m_req←0. x_gnt = m_gnt & owner==x & !drop (combinational). Store → IDLE; load/fetch → WAIT.
- WAIT: on m_rvalid: x_rvalid = owner==x & !drop, x_rdata = m_rdata (combinational passthrough); go IDLE.
- i_kill while owner==I in REQ or WAIT: drop←1 (sticky until IDLE). Bus transaction still completes; i_gnt and i_rvalid suppressed for it. i_kill has no effect on a D transaction.
- m_gnt outside REQ and m_rvalid outside WAIT: ignored, never forwarded.
- Requesters deassert req on the cycle after their gnt; re-asserting before rvalid is illegal for loads/fetches.

## Timing
- Reset (async assert): state IDLE, m_req=0, m_we=0, m_addr=0, m_wdata=0, m_be=0, streak=0, drop=0, owner=I. Therefore i_gnt=d_gnt=i_rvalid=d_rvalid=0 and i_rdata=d_rdata=0.
- Reset mid-REQ/WAIT: transaction abandoned; a late m_rvalid after release lands in IDLE and is dropped.
- Latency: req seen in cycle 0 (IDLE) → m_req=1 in cycle 1. With m_gnt in cycle 1 → x_gnt in cycle 1. With m_rvalid in cycle 2 → x_rvalid/x_rdata in cycle 2. Next arbitration in cycle 3.
- Store minimum occupancy: 2 cycles (IDLE+REQ). Load minimum occupancy: 3 cycles. Stalls in m_gnt/m_rvalid extend REQ/WAIT indefinitely.
- At most one outstanding memory transaction; throughput ≤1 access per 2 cycles.

## Test plan
- Fetch read: i_req=1, i_addr=0x100; m_gnt=1 first REQ cycle; m_rvalid=1, m_rdata=0xDEADBEEF next cycle → m_addr=0x100, m_we=0, m_be=0xF; i_gnt cycle 1; i_rvalid=1, i_rdata=0xDEADBEEF cycle 2; d_* outputs stay 0.
- Stalled store: d_we=1, d_addr=0x2000, d_wdata=0x12345678, d_be=0x3; m_gnt withheld 3 cycles → m_req and fields stable for 4 cycles; d_gnt pulses one cycle with m_gnt; no d_rvalid; IDLE next.
- Contention fairness, MAX_D_STREAK=4, both reqs continuously re-asserted, single-cycle memory → grant order D,D,D,D,I,D,D,D,D,I.
- Kill: fetch in WAIT, i_kill=1 for one cycle, m_rvalid two cycles later with 0xCAFEF00D → i_rvalid stays 0; next queued d_req is granted normally.
- Reset mid-WAIT: rst_n low during WAIT → all outputs 0 immediately. After release, a stray m_rvalid=1 and m_gnt=1 → no x_gnt/x_rvalid; state remains IDLE.
- Back-to-back: pending d_req and i_req arriving the cycle a load completes → arbitration occurs the next IDLE cycle; D wins (streak<max); i_req still held and later served.
